// File: rtl/ram_image_reader.sv
`default_nettype none
// ============================================================================
// Module   : ram_image_reader
// Raster-scan frame reader: synchronous RAM read port in, tagged pixel stream out.
// Revision : 1.0
// ============================================================================
module ram_image_reader #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 16,
  parameter int X_WIDTH = 8
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [A_WIDTH-1:0]         ram_address_o,
  input  logic [D_WIDTH-1:0]         ram_q_i,
  output logic [D_WIDTH-1:0]         pix_data_o,
  output logic [X_WIDTH-1:0]         pix_x_o,
  output logic [A_WIDTH-X_WIDTH-1:0] pix_y_o,
  output logic                       pix_sof_o,
  output logic                       pix_eol_o,
  output logic                       pix_eof_o,
  output logic                       pix_valid_o,
  input  logic                       pix_ready_i
);

  localparam int Y_WIDTH = A_WIDTH - X_WIDTH;
  localparam int DEPTH   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic               sof;
    logic               eol;
    logic               eof;
    logic [Y_WIDTH-1:0] y;
    logic [X_WIDTH-1:0] x;
    logic [D_WIDTH-1:0] data;
  } entry_t;

  state_t             state_q, state_d;
  logic [A_WIDTH:0]   addr_q, addr_d;
  logic [A_WIDTH-1:0] ram_address_q, ram_address_d;
  logic               p1_vld_q, p1_vld_d;
  logic               p2_vld_q, p2_vld_d;
  logic [A_WIDTH-1:0] p2_addr_q, p2_addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  entry_t             fifo_q [DEPTH];
  entry_t             fifo_d [DEPTH];
  logic [1:0]         wr_ptr_q, wr_ptr_d;
  logic [1:0]         rd_ptr_q, rd_ptr_d;
  logic [2:0]         cnt_q, cnt_d;

  logic               w_push;
  logic               w_pop;
  logic [3:0]         w_load;
  logic               w_can_issue;
  entry_t             w_entry;

  always_comb begin
    w_push = p2_vld_q;
    w_pop  = (cnt_q != 3'd0) && pix_ready_i;
    // Occupancy after this edge plus reads still in flight; crediting the
    // departing beat is what lets a read issue every cycle at full rate.
    w_load      = {1'b0, cnt_q} + {3'b000, p1_vld_q} + {3'b000, p2_vld_q} - {3'b000, w_pop};
    w_can_issue = (w_load < 4'd3);

    w_entry.data = ram_q_i;
    w_entry.x    = p2_addr_q[X_WIDTH-1:0];
    w_entry.y    = p2_addr_q[A_WIDTH-1:X_WIDTH];
    w_entry.sof  = (p2_addr_q == '0);
    w_entry.eol  = &p2_addr_q[X_WIDTH-1:0];
    w_entry.eof  = &p2_addr_q;

    state_d       = state_q;
    addr_d        = addr_q;
    ram_address_d = ram_address_q;
    p1_vld_d      = 1'b0;
    p2_vld_d      = p1_vld_q;
    p2_addr_d     = ram_address_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    fifo_d        = fifo_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (w_push) begin
      fifo_d[wr_ptr_q] = w_entry;
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    cnt_d = cnt_q + {2'b00, w_push} - {2'b00, w_pop};

    case (state_q)
      ST_IDLE: begin
        // Address 0 goes out on the accepting edge itself.
        if (start_i && !done_q) begin
          state_d       = ST_READ;
          busy_d        = 1'b1;
          ram_address_d = '0;
          p1_vld_d      = 1'b1;
          addr_d        = (A_WIDTH+1)'(1);
        end
      end
      ST_READ: begin
        if (w_can_issue) begin
          ram_address_d = addr_q[A_WIDTH-1:0];
          p1_vld_d      = 1'b1;
          addr_d        = addr_q + (A_WIDTH+1)'(1);
          if (addr_d[A_WIDTH]) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if ((cnt_q == 3'd0) && !p1_vld_q && !p2_vld_q) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      ram_address_q <= '0;
      p1_vld_q      <= 1'b0;
      p2_vld_q      <= 1'b0;
      p2_addr_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      wr_ptr_q      <= 2'd0;
      rd_ptr_q      <= 2'd0;
      cnt_q         <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      ram_address_q <= ram_address_d;
      p1_vld_q      <= p1_vld_d;
      p2_vld_q      <= p2_vld_d;
      p2_addr_q     <= p2_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      fifo_q        <= fifo_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign ram_address_o = ram_address_q;
  assign pix_valid_o   = (cnt_q != 3'd0);
  assign pix_data_o    = fifo_q[rd_ptr_q].data;
  assign pix_x_o       = fifo_q[rd_ptr_q].x;
  assign pix_y_o       = fifo_q[rd_ptr_q].y;
  assign pix_sof_o     = fifo_q[rd_ptr_q].sof;
  assign pix_eol_o     = fifo_q[rd_ptr_q].eol;
  assign pix_eof_o     = fifo_q[rd_ptr_q].eof;

endmodule
`default_nettype wire

// File: tb/tb_ram_image_reader.sv
`default_nettype none
// Scoreboard bench for ram_image_reader on a 4x4 frame with random back-pressure.
module tb_ram_image_reader;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int XW = 2;
  localparam int YW = AW - XW;
  localparam int N  = 1 << AW;
  localparam int BW = DW + XW + YW + 3;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic          ready = 1'b1;
  logic          busy, done, valid, sof, eol, eof;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_q = '0;
  logic [DW-1:0] pix_data;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic [DW-1:0] mem [N];
  logic [BW-1:0] act;

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= mem[ram_address];

  ram_image_reader #(.D_WIDTH(DW), .A_WIDTH(AW), .X_WIDTH(XW)) dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .start_i      (start),
    .busy_o       (busy),
    .done_o       (done),
    .ram_address_o(ram_address),
    .ram_q_i      (ram_q),
    .pix_data_o   (pix_data),
    .pix_x_o      (px),
    .pix_y_o      (py),
    .pix_sof_o    (sof),
    .pix_eol_o    (eol),
    .pix_eof_o    (eof),
    .pix_valid_o  (valid),
    .pix_ready_i  (ready)
  );

  assign act = {pix_data, px, py, sof, eol, eof};

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [BW-1:0] sb [$];
  int            beats_seen = 0;
  int            eof_age = -1;
  int            done_cnt = 0;
  int            cyc = 0;
  int            t5 = 0;
  int            mode = 0;
  int            stall_left = 0;
  bit            stall_done = 1'b0;
  bit            held_v = 1'b0;
  logic [BW-1:0] held;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference beat i of a raster scan, from the frame geometry alone.
  function automatic logic [BW-1:0] model_beat(input int i);
    int            x, y;
    logic [XW-1:0] xs;
    logic [YW-1:0] ys;
    x  = i % (1 << XW);
    y  = i / (1 << XW);
    xs = XW'(x);
    ys = YW'(y);
    return {mem[i], xs, ys, (i == 0), (x == (1 << XW) - 1), (i == N - 1)};
  endfunction

  // Monitor: done timing, stall stability and scoreboard pops.
  always @(negedge clk) begin
    logic [BW-1:0] want;
    cyc++;
    if (!rst) begin
      check("fifo_occupancy_le_4", 32'(dut.cnt_q <= 3'd4), 32'd1);
      if (eof_age >= 0) eof_age++;
      if (done) done_cnt++;
      if (eof_age == 2) begin
        check("done_after_last_beat", 32'(done), 32'd1);
        check("busy_low_with_done", 32'(busy), 32'd0);
        eof_age = -1;
      end else begin
        if (eof_age == 1) check("done_not_early", 32'(done), 32'd0);
        if (done) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got 1 expected 0 (t=%0t)", $time);
        end
      end
      if (held_v) begin
        check("stall_valid_held", 32'(valid), 32'd1);
        check("stall_beat_stable", 32'(act), 32'(held));
      end
      held_v = valid && !ready;
      held   = act;
      if (valid && ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected none (t=%0t)", act, $time);
        end else begin
          want = sb.pop_front();
          check($sformatf("beat%0d", beats_seen), 32'(act), 32'(want));
          if (want[0]) eof_age = 0;
        end
        if (mode == 2 && beats_seen == 5) t5 = cyc;
        if (mode == 2 && beats_seen == 15) check("post_stall_one_per_cycle", 32'(cyc - t5), 32'd10);
        beats_seen++;
      end
    end
  end

  // Ready driver: 0 = always ready, 1 = 50% random, 2 = 10-cycle stall at beat 5.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mode == 1) begin
        ready = 1'($urandom_range(0, 1));
      end else if (mode == 2) begin
        if (beats_seen == 5 && !stall_done) begin
          stall_left = 10;
          stall_done = 1'b1;
        end
        if (stall_left > 0) begin
          ready = 1'b0;
          stall_left--;
        end else begin
          ready = 1'b1;
        end
      end else begin
        ready = 1'b1;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic do_start();
    for (int i = 0; i < N; i++) sb.push_back(model_beat(i));
    beats_seen = 0;
    stall_done = 1'b0;
    pulse_start();
  endtask

  task automatic wait_done(input bit start_in_done);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 400);
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL frame_timeout: got no done expected done within 400 cycles");
    end
    check("frame_fully_delivered", 32'(sb.size()), 32'd0);
    if (start_in_done) pulse_start();
    else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_beats(input int n);
    int k;
    k = 0;
    while (beats_seen < n && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (beats_seen < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_timeout: got %0d beats expected %0d", beats_seen, n);
    end
  endtask

  task automatic flush();
    sb.delete();
    held_v  = 1'b0;
    eof_age = -1;
  endtask

  initial begin
    int d0;
    for (int i = 0; i < N; i++) mem[i] = DW'(i + 16);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_address", 32'(ram_address), 32'd0);
    check("reset_tags", 32'(act), 32'd0);
    @(posedge clk);
    #1;

    // Free-running frame
    mode = 0;
    d0   = done_cnt;
    do_start();
    @(negedge clk);
    check("busy_after_start", 32'(busy), 32'd1);
    check("address0_after_start", 32'(ram_address), 32'd0);
    check("valid_low_s0", 32'(valid), 32'd0);
    @(negedge clk);
    check("valid_low_s1", 32'(valid), 32'd0);
    @(negedge clk);
    check("valid_high_s2", 32'(valid), 32'd1);
    wait_done(1'b0);
    repeat (2) @(posedge clk);
    #1 check("one_done_free_run", 32'(done_cnt - d0), 32'd1);

    // Random back-pressure, last frame with random RAM contents
    mode = 1;
    for (int f = 0; f < 3; f++) begin
      if (f == 2) for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
      d0 = done_cnt;
      do_start();
      wait_done(1'b0);
      repeat (2) @(posedge clk);
      #1 check("one_done_random", 32'(done_cnt - d0), 32'd1);
    end
    for (int i = 0; i < N; i++) mem[i] = DW'(i + 16);

    // Long stall at beat 5
    mode = 2;
    do_start();
    wait_done(1'b0);

    // Start while busy, and in the done cycle
    mode = 0;
    d0   = done_cnt;
    do_start();
    wait_beats(3);
    pulse_start();
    wait_beats(15);
    pulse_start();
    wait_done(1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("ignored_starts_idle", 32'(busy), 32'd0);
    check("ignored_starts_one_done", 32'(done_cnt - d0), 32'd1);
    do_start();
    wait_done(1'b0);

    // Reset mid-frame
    d0 = done_cnt;
    do_start();
    wait_beats(7);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    flush();
    @(negedge clk);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_address", 32'(ram_address), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (20) @(posedge clk);
    #1 check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    do_start();
    wait_done(1'b0);

    // Reset and start together
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", 32'(busy), 32'd0);
    check("rst_start_valid", 32'(valid), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("rst_start_stays_idle", 32'(busy), 32'd0);
    check("rst_start_address", 32'(ram_address), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
